// File: rtl/multdiv_pkg.sv
// Shared types and defaults for the iterative multiply/divide sequencer.
// Optional early termination is enabled by defining MULTDIV_SEQ_EARLY_TERM_EN.
package multdiv_pkg;

  localparam int STEPS_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  typedef enum logic {
    OP_MUL,
    OP_DIV
  } op_t;

endpackage

// File: rtl/step_counter.sv
// Iteration counter for the multiply/divide sequencer: synchronous clear,
// enable, saturation at STEPS, and a flag marking the final iteration.
module step_counter
  import multdiv_pkg::*;
#(
  parameter  int STEPS = STEPS_DEFAULT,
  localparam int CNT_W = $clog2(STEPS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  // Holds at STEPS so a stray enable can never wrap the count back to zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal = (count == CNT_LAST);

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// Sequencer driving load/step strobes of the shift/add multiply/divide datapath.
// Define MULTDIV_SEQ_EARLY_TERM_EN to let multiplies finish on dp_early_done.
module multdiv_seq_ctrl
  import multdiv_pkg::*;
#(
  parameter  int STEPS = STEPS_DEFAULT,
  localparam int CNT_W = $clog2(STEPS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             divisor_zero,
  input  logic             dp_early_done,
  output logic             dp_load,
  output logic             dp_step,
  output logic             dp_is_div,
  output logic [CNT_W-1:0] step_count,
  output logic             busy,
  output logic             data_resultRDY,
  output logic             data_exception
);

  state_t state;
  state_t state_next;
  op_t    op_q;
  logic   exc_q;
  logic   start;
  logic   div_zero;
  logic   cnt_last;
  logic   last_step;

  assign start    = ctrl_MULT | ctrl_DIV;
  assign div_zero = (op_q == OP_DIV) & divisor_zero;

  // Clearing on entry to LOAD makes step_count read zero during the load cycle.
  step_counter #(
    .STEPS(STEPS)
  ) u_step_counter (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_next == LOAD),
    .enable  (state == RUN),
    .count   (step_count),
    .terminal(cnt_last)
  );

`ifdef MULTDIV_SEQ_EARLY_TERM_EN
  assign last_step = cnt_last | ((op_q == OP_MUL) & dp_early_done);
`else
  logic unused_early_done;
  assign unused_early_done = dp_early_done;
  assign last_step         = cnt_last;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A start pulse in any state (re)launches an op; MULT wins a tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q  <= OP_MUL;
      exc_q <= 1'b0;
    end else if (start) begin
      op_q  <= (ctrl_DIV & ~ctrl_MULT) ? OP_DIV : OP_MUL;
      exc_q <= 1'b0;
    end else if (state == LOAD) begin
      exc_q <= div_zero;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? LOAD : IDLE;
      LOAD:    state_next = start ? LOAD : (div_zero ? DONE : RUN);
      RUN:     state_next = start ? LOAD : (last_step ? DONE : RUN);
      DONE:    state_next = start ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dp_load        = 1'b0;
    dp_step        = 1'b0;
    busy           = 1'b0;
    data_resultRDY = 1'b0;
    data_exception = 1'b0;
    case (state)
      LOAD: begin
        dp_load = 1'b1;
        busy    = 1'b1;
      end
      RUN: begin
        dp_step = 1'b1;
        busy    = 1'b1;
      end
      DONE: begin
        data_resultRDY = 1'b1;
        data_exception = exc_q;
      end
      default: ;
    endcase
  end

  assign dp_is_div = (op_q == OP_DIV);

endmodule
